// File: rtl/plane_loader.sv
// plane_loader: write-bus master that uploads one LED plane (SETADDR, SETDIR, data bytes, ENABLE)
// and forwards single host command bytes. Define PLANE_LOADER_BLANK_EN to prefix uploads with BLANK (0x08).
module plane_loader #(
    parameter int OUT_NUM    = 64,
    parameter int D_WIDTH    = 8,
    parameter int C_WIDTH    = 5,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               cmdValid,
    input  logic [D_WIDTH-1:0] cmdByte,
    output logic               cmdReady,
    output logic [6:0]         rdAddr,
    input  logic [C_WIDTH-1:0] rdData,
    output logic [D_WIDTH-1:0] dataOut,
    output logic               dataEn,
    output logic               rs
);
    localparam int CNT_MAX = (STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [6:0]         IDX_LAST    = 7'(OUT_NUM - 1);
    localparam logic [D_WIDTH-1:0] CMD_BLANK   = D_WIDTH'(8'h08);
    localparam logic [D_WIDTH-1:0] CMD_SETADDR = D_WIDTH'(8'h80);
    localparam logic [D_WIDTH-1:0] CMD_SETDIR  = D_WIDTH'(8'h06);
    localparam logic [D_WIDTH-1:0] CMD_ENABLE  = D_WIDTH'(8'h0C);

    typedef enum logic [2:0] {
        S_IDLE, S_BLANK, S_SETADDR, S_SETDIR, S_DATA, S_ENABLE, S_DONE, S_CMD
    } state_e;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_e;

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         idx_q, idx_d;
    logic               last_q, last_d;
    logic [D_WIDTH-1:0] dout_q, dout_d;
    logic               rs_q, rs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               byte_end;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            dout_q  <= '0;
            rs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
            rs_q    <= rs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        last_d   = last_q;
        dout_d   = dout_q;
        rs_d     = rs_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        byte_end = 1'b0;

        // Byte phase engine; a data byte latches the RAM word and advances the read index in SETUP.
        if (state_q != S_IDLE && state_q != S_DONE) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_STROBE;
                    cnt_d   = '0;
                    if (state_q == S_DATA) begin
                        dout_d = D_WIDTH'(rdData);
                        if (idx_q == IDX_LAST) last_d = 1'b1;
                        else                   idx_d  = idx_q + 7'd1;
                    end
                end
                PH_STROBE: begin
                    if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
                        phase_d = PH_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CNT_W'(HOLD_CYC - 1)) byte_end = 1'b1;
                    else                               cnt_d    = cnt_q + 1'b1;
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                phase_d = PH_SETUP;
                cnt_d   = '0;
                if (start) begin
                    busy_d = 1'b1;
                    idx_d  = '0;
                    last_d = 1'b0;
                    rs_d   = 1'b1;
`ifdef PLANE_LOADER_BLANK_EN
                    state_d = S_BLANK;
                    dout_d  = CMD_BLANK;
`else
                    state_d = S_SETADDR;
                    dout_d  = CMD_SETADDR;
`endif
                end else if (cmdValid) begin
                    state_d = S_CMD;
                    dout_d  = cmdByte;
                    rs_d    = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (byte_end) begin
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    case (state_q)
                        S_BLANK: begin
                            state_d = S_SETADDR;
                            dout_d  = CMD_SETADDR;
                        end
                        S_SETADDR: begin
                            state_d = S_SETDIR;
                            dout_d  = CMD_SETDIR;
                        end
                        S_SETDIR: begin
                            state_d = S_DATA;
                            rs_d    = 1'b0;
                        end
                        S_DATA: begin
                            if (last_q) begin
                                state_d = S_ENABLE;
                                dout_d  = CMD_ENABLE;
                                rs_d    = 1'b1;
                            end
                        end
                        S_ENABLE: begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // The RAM word for a data byte arrives during its SETUP cycle, so it is passed straight through.
    assign dataOut  = (state_q == S_DATA && phase_q == PH_SETUP) ? D_WIDTH'(rdData) : dout_q;
    assign dataEn   = (phase_q == PH_STROBE);
    assign rs       = rs_q;
    assign rdAddr   = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cmdReady = (state_q == S_IDLE) & ~start;

endmodule

// File: tb/tb_plane_loader.sv
// tb_plane_loader: random-stimulus bench for plane_loader with a registered-RAM model and
// a byte-level plane receiver model. Honours PLANE_LOADER_BLANK_EN for the expected sequence.
module tb_plane_loader;
    localparam int OUT_NUM    = 64;
    localparam int D_WIDTH    = 8;
    localparam int C_WIDTH    = 5;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int BYTE_PER   = 1 + STROBE_CYC + HOLD_CYC;
`ifdef PLANE_LOADER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam int NBYTES = OUT_NUM + 3 + (BLANK ? 1 : 0);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               busy, done;
    logic               cmd_valid = 1'b0;
    logic [D_WIDTH-1:0] cmd_byte = '0;
    logic               cmd_ready;
    logic [6:0]         rd_addr;
    logic [C_WIDTH-1:0] rd_data = '0;
    logic [D_WIDTH-1:0] data_out;
    logic               data_en, rs;

    plane_loader #(
        .OUT_NUM(OUT_NUM), .D_WIDTH(D_WIDTH), .C_WIDTH(C_WIDTH),
        .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .cmdValid(cmd_valid), .cmdByte(cmd_byte), .cmdReady(cmd_ready),
        .rdAddr(rd_addr), .rdData(rd_data),
        .dataOut(data_out), .dataEn(data_en), .rs(rs)
    );

    always #5 clk = ~clk;

    // Host-side frame buffer behind a one-cycle registered read port.
    logic [C_WIDTH-1:0] buffer [128];
    always @(posedge clk) rd_data <= buffer[rd_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } bus_byte_t;

    // Receiver side: a byte is taken on each dataEn fall, with strobe/hold timing checked.
    bus_byte_t  seen_q[$];
    logic       en_prev = 1'b0;
    int         hi_cnt = 0;
    bus_byte_t  strobe_val;

    always @(negedge clk) begin
        if (reset) begin
            en_prev = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (data_en) begin
                if (!en_prev) begin
                    strobe_val = bus_byte_t'{rs, data_out};
                    hi_cnt     = 0;
                end else begin
                    check("strobe_stable", {rs, data_out}, strobe_val);
                end
                hi_cnt++;
            end else if (en_prev) begin
                check("strobe_len", hi_cnt, STROBE_CYC);
                check("hold_stable", {rs, data_out}, strobe_val);
                seen_q.push_back(strobe_val);
            end
            en_prev = data_en;
        end
    end

    logic [7:0] plane_mem [128];
    bit         plane_pwm;

    // Plane model: interprets the received byte stream; PWM assumed running before the upload.
    task automatic plane_apply(output int wr_pwm_on);
        int addr = 0;
        bit pwm  = 1'b1;
        wr_pwm_on = 0;
        foreach (plane_mem[i]) plane_mem[i] = 8'hFF;
        foreach (seen_q[k]) begin
            if (seen_q[k].rs) begin
                if (seen_q[k].data == 8'h08)      pwm  = 1'b0;
                else if (seen_q[k].data == 8'h0C) pwm  = 1'b1;
                else if (seen_q[k].data[7])       addr = int'(seen_q[k].data[6:0]);
            end else begin
                plane_mem[addr % 128] = seen_q[k].data;
                if (pwm) wr_pwm_on++;
                addr++;
            end
        end
        plane_pwm = pwm;
    endtask

    task automatic verify_upload(input string tag);
        bus_byte_t exp_q[$];
        int        n, bad, wr_on;
        if (BLANK) exp_q.push_back(bus_byte_t'{1'b1, 8'h08});
        exp_q.push_back(bus_byte_t'{1'b1, 8'h80});
        exp_q.push_back(bus_byte_t'{1'b1, 8'h06});
        for (int i = 0; i < OUT_NUM; i++) exp_q.push_back(bus_byte_t'{1'b0, 8'(buffer[i])});
        exp_q.push_back(bus_byte_t'{1'b1, 8'h0C});
        check({tag, "_nbytes"}, seen_q.size(), NBYTES);
        n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) check($sformatf("%s_byte%0d", tag, k), seen_q[k], exp_q[k]);
        plane_apply(wr_on);
        bad = 0;
        for (int i = 0; i < OUT_NUM; i++) if (plane_mem[i] !== 8'(buffer[i])) bad++;
        check({tag, "_plane_mem_bad"}, bad, 0);
        check({tag, "_plane_pwm_on"}, plane_pwm, 1);
        check({tag, "_writes_pwm_on"}, wr_on, BLANK ? 0 : OUT_NUM);
    endtask

    task automatic run_upload(input string tag, input bit with_cmd, input int mid_start);
        int done_at  = 0;
        int done_cnt = 0;
        bit busy_ok  = 1'b1;
        seen_q.delete();
        @(posedge clk);
        #1 start = 1'b1;
        cmd_valid = with_cmd;
        cmd_byte  = 8'h55;
        #0 check({tag, "_cmd_ready_start"}, cmd_ready, 0);
        @(posedge clk);
        #1 start = 1'b0;
        cmd_valid = 1'b0;
        for (int n = 1; n <= NBYTES * BYTE_PER + 6; n++) begin
            @(negedge clk);
            start = (n == mid_start);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
                if (busy) busy_ok = 1'b0;
            end else if (n <= NBYTES * BYTE_PER && !busy) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_done_at"}, done_at, NBYTES * BYTE_PER + 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_window"}, busy_ok, 1);
        verify_upload(tag);
    endtask

    task automatic run_cmd(input logic [7:0] b);
        int low = 0;
        int busy_seen = 0;
        seen_q.delete();
        @(posedge clk);
        #1 cmd_valid = 1'b1;
        cmd_byte = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (!cmd_ready) low++;
            if (busy || done) busy_seen++;
        end
        check("cmd_ready_low_cycles", low, BYTE_PER);
        check("cmd_no_busy_done", busy_seen, 0);
        check("cmd_nbytes", seen_q.size(), 1);
        if (seen_q.size() > 0) check("cmd_byte", seen_q[0], bus_byte_t'{1'b1, b});
    endtask

    initial begin
        int en_hits = 0;
        int rst_cyc;
        for (int i = 0; i < 128; i++) buffer[i] = C_WIDTH'(i & 31);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: nothing on the bus, ready for commands.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (data_en) en_hits++;
        end
        check("idle_en_hits", en_hits, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rd_addr", rd_addr, 0);
        check("idle_data_out", data_out, 0);
        check("idle_rs", rs, 0);
        check("idle_bytes", seen_q.size(), 0);

        run_cmd(8'h01);
        for (int r = 0; r < 3; r++) run_cmd(8'($urandom));

        run_upload("up_ramp", 1'b0, 0);

        for (int i = 0; i < 128; i++) buffer[i] = C_WIDTH'($urandom_range(0, 31));
        run_upload("up_start_cmd", 1'b1, 40);

        // Reset in the middle of DATA byte 10's strobe.
        seen_q.delete();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rst_cyc = ((BLANK ? 1 : 0) + 2 + 10) * BYTE_PER + 2;
        for (int n = 1; n <= rst_cyc; n++) @(negedge clk);
        check("mid_en_high", data_en, 1);
        check("mid_rs_data", rs, 0);
        check("mid_rd_addr", rd_addr, 11);
        reset = 1'b1;
        @(negedge clk);
        check("rst_en", data_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rs", rs, 0);
        check("rst_data_out", data_out, 0);
        check("rst_rd_addr", rd_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 128; i++) buffer[i] = C_WIDTH'($urandom_range(0, 31));
        run_upload("up_after_rst", 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
